// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths,
// displacement width and the fetch FSM state encoding.
package fetch_ctrl_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DISP_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_next_pc.sv
// Combinational next-PC logic: sequential increment and the redirect target
// (jump target, or branch base plus sign-extended displacement; jump wins).
module fetch_ctrl_next_pc
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_tgt_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic [DISP_W-1:0] displacement_i,
  output logic [ADDR_W-1:0] pc_inc_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] w_disp_ext;
  logic [ADDR_W-1:0] w_branch_tgt;

  // Both sums wrap modulo 2^ADDR_W, so all-ones + 1 lands on zero.
  assign w_disp_ext   = {{(ADDR_W-DISP_W){displacement_i[DISP_W-1]}}, displacement_i};
  assign w_branch_tgt = branch_pc_i + w_disp_ext;
  assign pc_inc_o     = pc_i + ADDR_W'(1);
  assign target_o     = jump_i ? jump_tgt_i : w_branch_tgt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, imem req/ack handshake, one-entry decode buffer
// and redirect squashing. Define FETCH_PERF_CNT_EN to add redirect/stall counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                INSTR_W   = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               halt_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  input  logic               instr_ready_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_tgt_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_pc_i,
  input  logic [DISP_W-1:0]  displacement_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        redirect_cnt_o,
  output logic [15:0]        stall_cnt_o
`endif
);

  fetch_state_e       r_state, w_state_nxt, w_resume_state;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic               r_valid, w_valid_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
  logic [ADDR_W-1:0]  w_pc_inc, w_target, w_drop_pc;
  logic               w_redirect;

  fetch_ctrl_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_i           (r_pc),
    .jump_i         (jump_i),
    .jump_tgt_i     (jump_tgt_i),
    .branch_pc_i    (branch_pc_i),
    .displacement_i (displacement_i),
    .pc_inc_o       (w_pc_inc),
    .target_o       (w_target)
  );

  assign w_redirect     = jump_i | branch_i;
  assign w_resume_state = halt_i ? ST_IDLE : ST_REQ;
  assign w_drop_pc      = w_redirect ? w_target : r_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_VEC;
      r_addr     <= RESET_VEC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

  // r_addr only changes on entry to REQ, so an outstanding request never moves;
  // DROP keeps the stale address on the bus while r_pc already holds the new target.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_addr_nxt     = r_addr;
    w_valid_nxt    = r_valid;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (!halt_i) begin
          w_state_nxt = ST_REQ;
          w_addr_nxt  = r_pc;
        end
      end
      ST_REQ: begin
        if (imem_ack_i && !w_redirect) begin
          w_instr_nxt    = imem_data_i;
          w_instr_pc_nxt = r_pc;
          w_pc_nxt       = w_pc_inc;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = ST_FULL;
        end else if (imem_ack_i) begin
          w_pc_nxt    = w_target;
          w_addr_nxt  = w_target;
          w_state_nxt = w_resume_state;
        end else if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_DROP;
        end
      end
      ST_FULL: begin
        if (w_redirect) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = w_target;
          w_addr_nxt  = w_target;
          w_state_nxt = w_resume_state;
        end else if (instr_ready_i) begin
          w_valid_nxt = 1'b0;
          w_addr_nxt  = r_pc;
          w_state_nxt = w_resume_state;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) begin
          w_pc_nxt    = w_drop_pc;
          w_addr_nxt  = w_drop_pc;
          w_state_nxt = w_resume_state;
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign imem_req_o    = (r_state == ST_REQ) || (r_state == ST_DROP);
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_redirect_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating counters; a cycle with both jump and branch is one redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_redirect && (r_redirect_cnt != 16'hFFFF))
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      if ((r_state == ST_FULL) && !instr_ready_i && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign redirect_cnt_o = r_redirect_cnt;
  assign stall_cnt_o    = r_stall_cnt;
`else
  // Performance counters compiled out: no extra ports or state.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level PC/instruction model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [15:0] imemData = '0;
  logic        instrValid;
  logic [15:0] instr;
  logic [15:0] instrPc;
  logic        instrReady = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jumpTgt = '0;
  logic        branch = 1'b0;
  logic [15:0] branchPc = '0;
  logic [7:0]  disp = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] redirectCnt;
  logic [15:0] stallCnt;
`endif

  int testsRun = 0;
  int failCount = 0;
  int reqAge = 0;
  int curWait = 0;
  int ackWait = 1;
  bit autoAck = 1'b1;
  bit randomWait = 1'b0;

  fetch_ctrl #(.ADDR_W(16), .INSTR_W(16), .RESET_VEC(16'h0000)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .halt_i         (halt),
    .imem_req_o     (imemReq),
    .imem_addr_o    (imemAddr),
    .imem_ack_i     (imemAck),
    .imem_data_i    (imemData),
    .instr_valid_o  (instrValid),
    .instr_o        (instr),
    .instr_pc_o     (instrPc),
    .instr_ready_i  (instrReady),
    .jump_i         (jump),
    .jump_tgt_i     (jumpTgt),
    .branch_i       (branch),
    .branch_pc_i    (branchPc),
    .displacement_i (disp)
`ifdef FETCH_PERF_CNT_EN
    ,
    .redirect_cnt_o (redirectCnt),
    .stall_cnt_o    (stallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [15:0] memData(input logic [15:0] a);
    return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
  endfunction

  function automatic logic [15:0] branchTarget(input logic [15:0] b, input logic [7:0] d);
    int sum;
    sum = int'(b) + int'($signed(d));
    return sum[15:0];
  endfunction

  // Advance one clock; sample point is 1ns after the edge, where the imem model
  // also decides whether to acknowledge the current request.
  task automatic applyStimulus();
    bit ackedLast;
    ackedLast = imemAck;
    @(posedge clk);
    #1;
    if (ackedLast || rst) reqAge = 0;
    if (autoAck) begin
      if (imemReq) begin
        if (reqAge == 0) curWait = randomWait ? int'($urandom_range(0, 3)) : ackWait;
        imemAck = (reqAge >= curWait);
        reqAge++;
      end else begin
        imemAck = 1'b0;
        reqAge = 0;
      end
      imemData = imemAck ? memData(imemAddr) : 16'($urandom);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1; halt = 1'b0; instrReady = 1'b0; jump = 1'b0; branch = 1'b0; imemAck = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic waitValid(output bit ok);
    instrReady = 1'b0;
    for (int i = 0; i < 30 && !instrValid; i++) applyStimulus();
    ok = instrValid;
  endtask

  task automatic test_reset();
    resetDut();
    testsRun++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_req: got %b want 0", imemReq); end
    testsRun++; if (imemAddr !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_addr: got %h want 0000", imemAddr); end
    testsRun++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b want 0", instrValid); end
    testsRun++; if (instr !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_instr: got %h want 0000", instr); end
    testsRun++; if (instrPc !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_instr_pc: got %h want 0000", instrPc); end
`ifdef FETCH_PERF_CNT_EN
    testsRun++; if (redirectCnt !== 16'd0 || stallCnt !== 16'd0) begin failCount++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", redirectCnt, stallCnt); end
`endif
  endtask

  task automatic test_sequential();
    int accepted = 0;
    int reqIdx = 0;
    int cycles = 0;
    bit prevAck, prevReq;
    instrReady = 1'b1; autoAck = 1'b1; ackWait = 1;
    while (accepted < 4 && cycles < 60) begin
      prevAck = imemAck; prevReq = imemReq;
      applyStimulus();
      cycles++;
      testsRun++; if (instrValid !== prevAck) begin failCount++; $display("[TB] FAIL seq_valid_latency: got %b want %b", instrValid, prevAck); end
      if (imemReq && (!prevReq || prevAck)) begin
        testsRun++; if (imemAddr !== 16'(reqIdx)) begin failCount++; $display("[TB] FAIL seq_req_addr: got %h want %h", imemAddr, 16'(reqIdx)); end
        reqIdx++;
      end
      if (instrValid) begin
        testsRun++; if (instrPc !== 16'(accepted)) begin failCount++; $display("[TB] FAIL seq_instr_pc: got %h want %h", instrPc, 16'(accepted)); end
        testsRun++; if (instr !== memData(16'(accepted))) begin failCount++; $display("[TB] FAIL seq_instr: got %h want %h", instr, memData(16'(accepted))); end
        accepted++;
      end
    end
    testsRun++; if (accepted != 4) begin failCount++; $display("[TB] FAIL seq_count: got %0d want 4", accepted); end
    applyStimulus();
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0004) begin failCount++; $display("[TB] FAIL seq_next_req: got %b/%h want 1/0004", imemReq, imemAddr); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] holdInstr, holdPc;
    waitValid(ok);
    testsRun++; if (!ok) begin failCount++; $display("[TB] FAIL stall_wait_valid: got 0 want 1"); end
    holdInstr = instr; holdPc = instrPc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      testsRun++; if (instrValid !== 1'b1 || instr !== holdInstr || instrPc !== holdPc || imemReq !== 1'b0) begin
        failCount++; $display("[TB] FAIL stall_hold: got v=%b i=%h pc=%h req=%b want v=1 i=%h pc=%h req=0", instrValid, instr, instrPc, imemReq, holdInstr, holdPc);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    testsRun++; if (stallCnt !== 16'd5) begin failCount++; $display("[TB] FAIL stall_cnt: got %0d want 5", stallCnt); end
`endif
    instrReady = 1'b1;
    applyStimulus();
  endtask

  task automatic test_jump_inflight();
    bit found = 1'b0;
    resetDut();
    instrReady = 1'b1; autoAck = 1'b1; ackWait = 1;
    for (int i = 0; i < 60 && !found; i++) begin
      applyStimulus();
      found = imemReq && (imemAddr == 16'h0003);
    end
    testsRun++; if (!found) begin failCount++; $display("[TB] FAIL jump_find_req3: got 0 want 1"); end
    autoAck = 1'b0; imemAck = 1'b0;
    jump = 1'b1; jumpTgt = 16'h0040;
    applyStimulus();
    jump = 1'b0;
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0003 || instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL jump_hold1: got req=%b addr=%h v=%b want 1/0003/0", imemReq, imemAddr, instrValid); end
    applyStimulus();
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0003) begin failCount++; $display("[TB] FAIL jump_hold2: got req=%b addr=%h want 1/0003", imemReq, imemAddr); end
    imemAck = 1'b1; imemData = 16'hDEAD;
    applyStimulus();
    imemAck = 1'b0;
    testsRun++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL jump_discard: got valid %b want 0", instrValid); end
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0040) begin failCount++; $display("[TB] FAIL jump_new_req: got %b/%h want 1/0040", imemReq, imemAddr); end
    imemAck = 1'b1; imemData = memData(16'h0040);
    applyStimulus();
    imemAck = 1'b0;
    testsRun++; if (instrValid !== 1'b1 || instrPc !== 16'h0040 || instr !== memData(16'h0040)) begin failCount++; $display("[TB] FAIL jump_target_instr: got v=%b pc=%h i=%h want 1/0040/%h", instrValid, instrPc, instr, memData(16'h0040)); end
`ifdef FETCH_PERF_CNT_EN
    testsRun++; if (redirectCnt !== 16'd1) begin failCount++; $display("[TB] FAIL jump_cnt: got %0d want 1", redirectCnt); end
`endif
    applyStimulus();
    autoAck = 1'b1;
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0041) begin failCount++; $display("[TB] FAIL jump_seq_after: got %b/%h want 1/0041", imemReq, imemAddr); end
  endtask

  task automatic test_branch_full();
    bit ok;
    logic [15:0] cnt0 = '0;
    waitValid(ok);
    testsRun++; if (!ok) begin failCount++; $display("[TB] FAIL branch_wait_valid: got 0 want 1"); end
    branch = 1'b1; branchPc = 16'h0010; disp = 8'hF8; instrReady = 1'b1;
    applyStimulus();
    branch = 1'b0; instrReady = 1'b0;
    testsRun++; if (instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL branch_squash: got valid %b want 0", instrValid); end
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0008) begin failCount++; $display("[TB] FAIL branch_target: got %b/%h want 1/0008", imemReq, imemAddr); end
    waitValid(ok);
    testsRun++; if (!ok || instrPc !== 16'h0008) begin failCount++; $display("[TB] FAIL branch_instr_pc: got %h want 0008", instrPc); end
`ifdef FETCH_PERF_CNT_EN
    cnt0 = redirectCnt;
`endif
    jump = 1'b1; jumpTgt = 16'h0123; branch = 1'b1; branchPc = 16'h0200; disp = 8'h05;
    applyStimulus();
    jump = 1'b0; branch = 1'b0;
    testsRun++; if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 16'h0123) begin failCount++; $display("[TB] FAIL both_jump_wins: got v=%b req=%b addr=%h want 0/1/0123", instrValid, imemReq, imemAddr); end
`ifdef FETCH_PERF_CNT_EN
    testsRun++; if (redirectCnt !== cnt0 + 16'd1) begin failCount++; $display("[TB] FAIL both_cnt: got %0d want %0d", redirectCnt, cnt0 + 16'd1); end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    waitValid(ok);
    testsRun++; if (!ok) begin failCount++; $display("[TB] FAIL wrap_wait_valid: got 0 want 1"); end
    jump = 1'b1; jumpTgt = 16'hFFFF;
    applyStimulus();
    jump = 1'b0;
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'hFFFF) begin failCount++; $display("[TB] FAIL wrap_first: got %b/%h want 1/ffff", imemReq, imemAddr); end
    waitValid(ok);
    testsRun++; if (!ok || instrPc !== 16'hFFFF || instr !== memData(16'hFFFF)) begin failCount++; $display("[TB] FAIL wrap_instr: got pc=%h i=%h want ffff/%h", instrPc, instr, memData(16'hFFFF)); end
    instrReady = 1'b1;
    applyStimulus();
    instrReady = 1'b0;
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin failCount++; $display("[TB] FAIL wrap_next: got %b/%h want 1/0000", imemReq, imemAddr); end
  endtask

  task automatic test_reset_drop();
    autoAck = 1'b0; imemAck = 1'b0;
    jump = 1'b1; jumpTgt = 16'h0077;
    applyStimulus();
    jump = 1'b0;
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin failCount++; $display("[TB] FAIL drop_hold: got %b/%h want 1/0000", imemReq, imemAddr); end
    rst = 1'b1;
    applyStimulus();
    testsRun++; if (imemReq !== 1'b0 || imemAddr !== 16'h0000 || instrValid !== 1'b0) begin failCount++; $display("[TB] FAIL drop_reset: got req=%b addr=%h v=%b want 0/0000/0", imemReq, imemAddr, instrValid); end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    applyStimulus();
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0000) begin failCount++; $display("[TB] FAIL halt_first_req: got %b/%h want 1/0000", imemReq, imemAddr); end
    halt = 1'b1; imemAck = 1'b1; imemData = memData(16'h0000);
    applyStimulus();
    imemAck = 1'b0;
    testsRun++; if (instrValid !== 1'b1 || imemReq !== 1'b0 || instrPc !== 16'h0000) begin failCount++; $display("[TB] FAIL halt_ack_completes: got v=%b req=%b pc=%h want 1/0/0000", instrValid, imemReq, instrPc); end
    applyStimulus();
    testsRun++; if (instrValid !== 1'b1) begin failCount++; $display("[TB] FAIL halt_keeps_buffer: got %b want 1", instrValid); end
    instrReady = 1'b1;
    applyStimulus();
    instrReady = 1'b0;
    testsRun++; if (instrValid !== 1'b0 || imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL halt_idle: got v=%b req=%b want 0/0", instrValid, imemReq); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      testsRun++; if (imemReq !== 1'b0) begin failCount++; $display("[TB] FAIL halt_no_req: got %b want 0", imemReq); end
    end
    halt = 1'b0;
    applyStimulus();
    testsRun++; if (imemReq !== 1'b1 || imemAddr !== 16'h0001) begin failCount++; $display("[TB] FAIL halt_resume: got %b/%h want 1/0001", imemReq, imemAddr); end
  endtask

  // Model: every accepted instruction carries the PC after the previous accepted
  // one, unless a redirect happened since, in which case it is the newest target.
  task automatic test_random();
    logic [15:0] expPc = 16'h0000;
    logic [15:0] holdAddr;
    int accepted = 0;
    int expRedir = 0;
    int expStall = 0;
    bit redirect, reqHold;
    resetDut();
    autoAck = 1'b1; randomWait = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      instrReady = ($urandom_range(0, 9) < 6);
      halt       = ($urandom_range(0, 9) < 2);
      jump       = ($urandom_range(0, 15) == 0);
      branch     = ($urandom_range(0, 15) == 0);
      jumpTgt    = 16'($urandom);
      branchPc   = 16'($urandom);
      disp       = 8'($urandom);
      redirect   = jump | branch;
      if (instrValid && instrReady && !redirect) begin
        testsRun++; if (instrPc !== expPc) begin failCount++; $display("[TB] FAIL rand_instr_pc: got %h want %h", instrPc, expPc); end
        testsRun++; if (instr !== memData(expPc)) begin failCount++; $display("[TB] FAIL rand_instr: got %h want %h", instr, memData(expPc)); end
        expPc = expPc + 16'd1;
        accepted++;
      end
      if (redirect) begin
        expPc = jump ? jumpTgt : branchTarget(branchPc, disp);
        expRedir++;
      end
      if (instrValid && !instrReady) expStall++;
      reqHold = imemReq && !imemAck;
      holdAddr = imemAddr;
      applyStimulus();
      if (reqHold) begin
        testsRun++; if (imemReq !== 1'b1 || imemAddr !== holdAddr) begin failCount++; $display("[TB] FAIL rand_req_stable: got %b/%h want 1/%h", imemReq, imemAddr, holdAddr); end
      end
    end
    jump = 1'b0; branch = 1'b0; halt = 1'b0; randomWait = 1'b0;
    testsRun++; if (accepted < 20) begin failCount++; $display("[TB] FAIL rand_progress: got %0d accepted want >= 20", accepted); end
`ifdef FETCH_PERF_CNT_EN
    testsRun++; if (redirectCnt !== 16'(expRedir)) begin failCount++; $display("[TB] FAIL rand_redirect_cnt: got %0d want %0d", redirectCnt, expRedir); end
    testsRun++; if (stallCnt !== 16'(expStall)) begin failCount++; $display("[TB] FAIL rand_stall_cnt: got %0d want %0d", stallCnt, expStall); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump_inflight();
    test_branch_full();
    test_wrap();
    test_reset_drop();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
